// File: rtl/nn_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nn_ctrl_pkg                                                                |
// | Layer-sequencing state encodings plus layer size / weight base helpers.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package nn_ctrl_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam int LAYER_MAX = 2;

  function automatic int layer_n_in(input logic [1:0] layer, input int inputs_l0,
                                    input int neurons_l0, input int neurons_l1);
    case (layer)
      2'd0:    return inputs_l0;
      2'd1:    return neurons_l0;
      2'd2:    return neurons_l1;
      default: return 0;
    endcase
  endfunction

  function automatic int layer_n_out(input logic [1:0] layer, input int neurons_l0,
                                     input int neurons_l1, input int neurons_l2);
    case (layer)
      2'd0:    return neurons_l0;
      2'd1:    return neurons_l1;
      2'd2:    return neurons_l2;
      default: return 0;
    endcase
  endfunction

  // extra is 1 when every neuron carries a bias word after its input weights
  function automatic int layer_base(input logic [1:0] layer, input int inputs_l0,
                                    input int neurons_l0, input int neurons_l1,
                                    input int extra);
    int span0;
    int span1;
    span0 = neurons_l0 * (inputs_l0 + extra);
    span1 = neurons_l1 * (neurons_l0 + extra);
    case (layer)
      2'd1:    return span0;
      2'd2:    return span0 + span1;
      default: return 0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lat_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lat_pipe                                                                   |
// | Fixed-depth shift register with synchronous clear, matching RAM latency.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lat_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/layer_ram_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | layer_ram_controller                                                       |
// | Walks one layer's neurons/inputs, driving RAM reads, MAC strobes, writes.  |
// | Optional macro RAM_CTRL_BIAS_EN adds a per-neuron bias read (bias_sel).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module layer_ram_controller
  import nn_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int IDX_W      = 8,
  parameter int INPUTS_L0  = 4,
  parameter int NEURONS_L0 = 3,
  parameter int NEURONS_L1 = 3,
  parameter int NEURONS_L2 = 2,
  parameter int RAM_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        layer,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_re,
  output logic [IDX_W-1:0]  x_addr,
  output logic              x_re,
  output logic              acc_clr,
  output logic              acc_en,
`ifdef RAM_CTRL_BIAS_EN
  output logic              bias_sel,
`endif
  output logic [IDX_W-1:0]  y_addr,
  output logic              y_we
);

`ifdef RAM_CTRL_BIAS_EN
  localparam int c_BIAS   = 1;
  localparam int c_PIPE_W = 2;
`else
  localparam int c_BIAS   = 0;
  localparam int c_PIPE_W = 1;
`endif
  localparam int c_DRAIN_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [c_DRAIN_W-1:0] c_LAT_LAST = c_DRAIN_W'(RAM_LAT - 1);

  logic [2:0]           r_state;
  logic [2:0]           w_next;
  logic [1:0]           r_layer;
  logic [IDX_W-1:0]     r_neuron;
  logic [IDX_W-1:0]     r_in_idx;
  logic [ADDR_W-1:0]    r_w_ptr;
  logic [c_DRAIN_W-1:0] r_drain;

  logic [IDX_W-1:0]     w_n_in;
  logic [IDX_W-1:0]     w_n_out;
  logic [IDX_W-1:0]     w_last_in;
  logic [ADDR_W-1:0]    w_base;
  logic                 w_bias_rd;
  logic [c_PIPE_W-1:0]  w_pipe_d;
  logic [c_PIPE_W-1:0]  w_pipe_q;

  assign w_n_in    = IDX_W'(layer_n_in(r_layer, INPUTS_L0, NEURONS_L0, NEURONS_L1));
  assign w_n_out   = IDX_W'(layer_n_out(r_layer, NEURONS_L0, NEURONS_L1, NEURONS_L2));
  // With bias, the READ run is one cycle longer: the bias word sits at index n_in.
  assign w_last_in = w_n_in - IDX_W'(1 - c_BIAS);
  assign w_base    = ADDR_W'(layer_base(layer, INPUTS_L0, NEURONS_L0, NEURONS_L1, c_BIAS));

`ifdef RAM_CTRL_BIAS_EN
  assign w_bias_rd = (r_state == READ) && (r_in_idx == w_n_in);
  assign w_pipe_d  = {w_bias_rd, (r_state == READ)};
  assign acc_en    = w_pipe_q[0];
  assign bias_sel  = w_pipe_q[1];
`else
  assign w_bias_rd = 1'b0;
  assign w_pipe_d  = (r_state == READ);
  assign acc_en    = w_pipe_q[0];
`endif

  lat_pipe #(
    .DEPTH (RAM_LAT),
    .WIDTH (c_PIPE_W)
  ) u_lat_pipe (
    .clk   (clk),
    .reset (reset),
    .d     (w_pipe_d),
    .q     (w_pipe_q)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_next = (layer > 2'(LAYER_MAX)) ? DONE : CLEAR;
      end
      CLEAR: w_next = READ;
      READ: begin
        if (r_in_idx == w_last_in) w_next = DRAIN;
      end
      DRAIN: begin
        if (r_drain == c_LAT_LAST) w_next = WRITE;
      end
      WRITE: w_next = (r_neuron == w_n_out - IDX_W'(1)) ? DONE : CLEAR;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Layer latch and walk counters; the layer only loads while IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_layer  <= '0;
      r_neuron <= '0;
      r_in_idx <= '0;
      r_w_ptr  <= '0;
      r_drain  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_layer  <= layer;
            r_neuron <= '0;
            r_w_ptr  <= w_base;
          end
        end
        CLEAR: begin
          r_in_idx <= '0;
          r_drain  <= '0;
        end
        READ: begin
          r_in_idx <= r_in_idx + IDX_W'(1);
          r_w_ptr  <= r_w_ptr + ADDR_W'(1);
        end
        DRAIN: r_drain <= r_drain + c_DRAIN_W'(1);
        WRITE: begin
          if (r_neuron != w_n_out - IDX_W'(1)) r_neuron <= r_neuron + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy    = (r_state != IDLE);
    done    = 1'b0;
    acc_clr = 1'b0;
    w_re    = 1'b0;
    w_addr  = '0;
    x_re    = 1'b0;
    x_addr  = '0;
    y_we    = 1'b0;
    y_addr  = '0;
    case (r_state)
      CLEAR: acc_clr = 1'b1;
      READ: begin
        w_re   = 1'b1;
        w_addr = r_w_ptr;
        x_re   = !w_bias_rd;
        x_addr = w_bias_rd ? '0 : r_in_idx;
      end
      WRITE: begin
        y_we   = 1'b1;
        y_addr = r_neuron;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/layer_ram_controller.md
# layer_ram_controller

Responder side of the layer-sequencing handshake. It accepts a one-cycle `start` pulse and a `layer` index from the network controller. For that layer it walks every neuron and every input, issuing weight-RAM and activation-RAM reads, multiply-accumulate strobes and result writes. When the layer is complete it returns a one-cycle `done` pulse. It sits between the network controller and the weight/activation RAMs plus the MAC datapath.

## Interface
- `ADDR_W`, 12: weight RAM address width.
- `IDX_W`, 8: neuron/input index width.
- `INPUTS_L0`, 4: input count of layer 0.
- `NEURONS_L0`, 3: neuron count of layer 0; also the input count of layer 1.
- `NEURONS_L1`, 3: neuron count of layer 1; also the input count of layer 2.
- `NEURONS_L2`, 2: neuron count of layer 2.
- `RAM_LAT`, 1: RAM read latency in cycles, at least 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `layer`  in  2  layer index, sampled with `start`.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in every state except IDLE.
- `w_addr`  out  ADDR_W  weight RAM read address.
- `w_re`  out  1  weight read enable.
- `x_addr`  out  IDX_W  activation read index.
- `x_re`  out  1  activation read enable.
- `acc_clr`  out  1  clear accumulator.
- `acc_en`  out  1  accumulate; aligned with RAM data (read enable delayed by `RAM_LAT`).
- `y_addr`  out  IDX_W  result neuron index.
- `y_we`  out  1  result write enable.

## Operation
- Outputs are Moore-decoded from registered state and counters. There is no combinational path from any input to any output.
- Per-layer sizes: `n_in` is `INPUTS_L0`, `NEURONS_L0` or `NEURONS_L1`; `n_out` is `NEURONS_L0`, `NEURONS_L1` or `NEURONS_L2`.
- Weight base addresses:
  - base0 = 0
  - base1 = `NEURONS_L0`·`INPUTS_L0`
  - base2 = base1 + `NEURONS_L1`·`NEURONS_L0`
  - The weight pointer runs contiguously from the base across all neurons.
- States:
  - IDLE: on `start`, latch `layer`, set neuron=0, load w_ptr=base → CLEAR. If `layer`==3, go → DONE instead.
  - CLEAR: `acc_clr`=1; set in_idx=0 → READ.
  - READ: `w_re`=`x_re`=1, `w_addr`=w_ptr, `x_addr`=in_idx. w_ptr and in_idx increment each cycle. When in_idx==n_in−1 → DRAIN.
  - DRAIN: stay `RAM_LAT` cycles, until the last `acc_en` has issued → WRITE.
  - WRITE: `y_we`=1, `y_addr`=neuron. If neuron==n_out−1 → DONE; otherwise neuron++ → CLEAR.
  - DONE: `done`=1 → IDLE.
- `start` outside IDLE is ignored; the latched layer does not change.
- Reset, including mid-operation:
  - state goes to IDLE and all counters clear.
  - every output is 0 (`w_addr`, `x_addr` and `y_addr` also 0).
  - the `acc_en` delay line is flushed and no `done` is produced.
- Counters never wrap within a layer. Parameters are legal only if base2 + `NEURONS_L2`·`NEURONS_L1` ≤ 2^ADDR_W and every count is < 2^IDX_W.

## Timing
- Edge E0 samples `start`; CLEAR occupies the following cycle.
- Each neuron takes n_in+`RAM_LAT`+2 cycles.
- `done` is high in the cycle that begins at E0 + n_out·(n_in+`RAM_LAT`+2).
- With an invalid layer (3), `done` is high in the cycle right after E0.
- `acc_en` goes high exactly `RAM_LAT` cycles after each read cycle. The final `acc_en` lands in the last DRAIN cycle, so `y_we` sees the completed sum.
- Because `start` is honoured only in IDLE, the earliest new `start` is the cycle after `done`.

## Configuration
- Macro `RAM_CTRL_BIAS_EN`.
- Defined:
  - each neuron gets one extra READ cycle after its inputs, with `w_re`=1, `x_re`=0 and extra output `bias_sel`=1. `bias_sel` passes through the same `RAM_LAT` delay as `acc_en`.
  - weight stride per neuron becomes n_in+1, and the base formulas use (inputs+1).
  - per-neuron time becomes n_in+`RAM_LAT`+3.
- Undefined: no `bias_sel` port and the timing is as stated above.

## Structure
- Shared package `nn_ctrl_pkg` holds:
  - state encodings (IDLE, CLEAR, READ, DRAIN, WRITE, DONE);
  - `LAYER_MAX`=2;
  - the base-address and layer-size selection functions, which the network controller also uses.
- One sub-module, `lat_pipe`: a parameterized-depth shift register that delays `acc_en` (and `bias_sel`) by `RAM_LAT`, with synchronous clear.

## Test plan
All scenarios use the default parameters.
1. Reset, then `start` with `layer`=0:
   - `w_addr` runs 0..11 and `x_addr` cycles 0..3.
   - `y_we` pulses with `y_addr` 0, 1, 2.
   - a single `done` in the cycle starting at E0+21.
2. `start` with `layer`=2:
   - first `w_addr`=21, `x_addr` runs 0..2, `y_addr` 0 then 1.
   - `done` at E0+12.
3. `start` pulsed again in mid-READ of layer 1: ignored. Addresses continue 12..20 and exactly one `done` is produced.
4. `reset` asserted in mid-READ: the next cycle has all outputs 0 and `busy`=0, and no `done` follows. A new `start` with `layer`=0 resumes from `w_addr`=0.
5. `start` with `layer`=3: `done` at E0+1, with no `w_re`, `x_re` or `y_we` activity.
6. With `RAM_CTRL_BIAS_EN` defined and `layer`=0:
   - per-neuron stride is 5, so `w_addr` runs 0..14.
   - `bias_sel` appears once per neuron, aligned with `acc_en`.
   - `done` at E0+24.
